safety_obi_mem_responder: RTL

// Responder end of the core's OBI-style instruction/data memory interface (req/gnt/rvalid, in-order, no rready).

---
 rtl/safety_obi_mem_responder_if.sv | 24 ++
 rtl/safety_obi_mem_responder.sv | 86 ++++++++
 2 files changed

// File: rtl/safety_obi_mem_responder_if.sv
// OBI-style request/response bundle between a core-side master and the memory responder.
interface safety_obi_mem_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        stall_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, stall_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, stall_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/safety_obi_mem_responder.sv
// Word-addressed SRAM responder for an in-order OBI-style bus: fixed response latency,
// bounded outstanding transactions, out-of-range accesses answered with an error.
module safety_obi_mem_responder #(
  parameter int unsigned NumWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  safety_obi_mem_responder_if.slave    bus
);

  localparam int unsigned AW       = $clog2(NumWords);
  localparam int unsigned CW       = $clog2(MaxOutstanding + 1);
  localparam logic [31:0] MissData = 32'hBADC_AB1E;

  logic [31:0]           mem [NumWords];
  logic [CW-1:0]         outstanding;
  logic [RspLatency-1:0] vld_p;
  logic                  err_p   [RspLatency];
  logic [31:0]           rdata_p [RspLatency];

  logic [31:0]   offset;
  logic          hit;
  logic [AW-1:0] word_idx;
  logic          gnt;
  logic          rvalid;

  // Unsigned offset makes addresses below BaseAddr wrap high and miss.
  assign offset   = bus.addr_i - BaseAddr;
  assign hit      = (offset >> (AW + 2)) == '0;
  assign word_idx = offset[AW+1:2];
  assign rvalid   = vld_p[RspLatency-1];

  // The slot freed by this cycle's response may be granted again immediately.
  assign gnt = bus.req_i && !bus.stall_i && rst_ni &&
               ((outstanding < CW'(MaxOutstanding)) || rvalid);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
      vld_p       <= '0;
    end else begin
      case ({gnt, rvalid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      vld_p[0] <= gnt;
      for (int i = 1; i < int'(RspLatency); i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Stage 0: storage access on the grant edge; later stages only delay the response.
  always_ff @(posedge clk_i) begin
    if (gnt) begin
      if (!hit) begin
        err_p[0]   <= 1'b1;
        rdata_p[0] <= MissData;
      end else if (bus.we_i) begin
        err_p[0]   <= 1'b0;
        rdata_p[0] <= '0;
        for (int k = 0; k < 4; k++) begin
          if (bus.be_i[k]) mem[word_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
        end
      end else begin
        err_p[0]   <= 1'b0;
        rdata_p[0] <= mem[word_idx];
      end
    end
    for (int i = 1; i < int'(RspLatency); i++) begin
      err_p[i]   <= err_p[i-1];
      rdata_p[i] <= rdata_p[i-1];
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rvalid ? rdata_p[RspLatency-1] : '0;
  assign bus.err_o    = rvalid && err_p[RspLatency-1];
  assign bus.busy_o   = (outstanding != '0);

endmodule
